// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M-style multiply/divide unit: op encodings,
// FSM states and width-dependent constant helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Callers truncate the result to their own width.
  function automatic logic [63:0] all_ones(input int unsigned w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/muldiv_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// the final sign fix-up of products, quotients and remainders.
module muldiv_neg #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value,
  input  logic            neg,
  output logic [XLEN-1:0] result
);

  assign result = neg ? (~value + XLEN'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (shift-add multiply, restoring divide).
// Optional early-out for trivial cases is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));

  state_e state, next_state;
  op_e op;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] opnd;
  logic [2*XLEN-1:0] acc, acc_step, fix_src, fixed;
  logic res_neg, div_zero;

  logic in_div, a_signed, b_signed, a_neg, b_neg, accept, early;
  logic [XLEN-1:0] mag_a, mag_b, early_val, final_val;
  logic [XLEN:0] mul_sum, rem_shift, diff;

  assign in_div   = func3[2];
  assign a_signed = in_div ? ~func3[0] : (func3[1:0] != 2'b11);
  assign b_signed = in_div ? ~func3[0] : ~func3[1];
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];

  muldiv_neg #(.XLEN(XLEN)) u_neg_a (.value(a), .neg(a_neg), .result(mag_a));
  muldiv_neg #(.XLEN(XLEN)) u_neg_b (.value(b), .neg(b_neg), .result(mag_b));

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));
  logic div_by_zero, ovf, mul_zero;

  assign div_by_zero = in_div & (b == '0);
  assign ovf         = in_div & ~func3[0] & (a == MOST_NEG) & (b == ONES);
  assign mul_zero    = ~in_div & ((a == '0) | (b == '0));
  assign early       = div_by_zero | ovf | mul_zero;

  always_comb begin
    early_val = '0;
    if (div_by_zero) early_val = func3[1] ? a : ONES;
    else if (ovf)    early_val = func3[1] ? '0 : a;
  end
`else
  assign early     = 1'b0;
  assign early_val = '0;
`endif

  assign accept = start & ~kill & ((state == IDLE) | (state == FIN));

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign diff      = rem_shift - {1'b0, opnd};

  always_comb begin
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (op[2]) begin
      acc_step = diff[XLEN] ? {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Divide results are zero-extended so one wide negator serves every op.
  assign fix_src = !op[2] ? acc_step
                          : {{XLEN{1'b0}}, (op[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0])};

  muldiv_neg #(.XLEN(2*XLEN)) u_neg_res (.value(fix_src), .neg(res_neg), .result(fixed));

  always_comb begin
    final_val = fixed[XLEN-1:0];
    if (!op[2] && (op != OP_MUL))            final_val = fixed[2*XLEN-1:XLEN];
    else if (op[2] && !op[1] && div_zero)    final_val = ONES;
  end

  always_comb begin
    next_state = state;
    busy       = (state == CALC) && !rst;
    done       = (state == FIN) && !kill && !rst;
    case (state)
      IDLE:    if (accept) next_state = early ? FIN : CALC;
      CALC: begin
        if (kill)              next_state = IDLE;
        else if (cnt == LAST)  next_state = FIN;
      end
      FIN:     next_state = accept ? (early ? FIN : CALC) : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result   <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= OP_MUL;
      res_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        op       <= op_e'(func3);
        cnt      <= '0;
        acc      <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
        opnd     <= in_div ? mag_b : mag_a;
        res_neg  <= (in_div && func3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero <= (b == '0);
        if (early) result <= early_val;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
        if ((cnt == LAST) && !kill) result <= final_val;
      end
    end
  end

endmodule
